// File: rtl/add_share_pkg.sv
// Shared types for the shared-adder arbiter.
// Provides FSM state encoding, default width and index-width helper.
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam int W_DEF = 8;

  // Width of an index into n requesters (min 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_share_arb_rr_pick.sv
// Combinational round-robin picker: first req at ptr, ptr+1, ... mod NREQ.
// Ports: req, ptr in; win (one-hot), idx, valid out.
module rr_pick
  import add_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int j;
    j     = 0;
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin sequencer sharing one registered W-bit adder among NREQ clients.
// Ports: clk, rst_n, ena, req, op_a, op_b in; ack, gnt, sum, carry, busy out.
// Option: define ADD_SHARE_SAT_EN to saturate sum to all-ones on carry.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      sum,
  output logic              carry,
  output logic              busy
);

  localparam int PW = idx_w(NREQ);

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            pick_vld;
  logic            grant;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W-1:0]    sum_nx;
  logic [W:0]      add_w;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (pick_oh),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign grant = (state == IDLE) && ena && pick_vld;
  assign busy  = (state != IDLE);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        a_sel = op_a[i*W +: W];
        b_sel = op_b[i*W +: W];
      end
    end
  end

  assign add_w = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADD_SHARE_SAT_EN
  assign sum_nx = add_w[W] ? '1 : add_w[W-1:0];
`else
  assign sum_nx = add_w[W-1:0];
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      win_idx <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt     <= '0;
      ack     <= '0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      state <= state_nx;
      ack   <= '0;
      if (grant) begin
        win_idx <= pick_idx;
        a_q     <= a_sel;
        b_q     <= b_sel;
        gnt     <= pick_oh;
      end
      // ack is registered so it is high for the RESP cycle only
      if (state == EXEC) begin
        sum   <= sum_nx;
        carry <= add_w[W];
        ack   <= gnt;
      end
      if (state == RESP) begin
        gnt <= '0;
        ptr <= (win_idx == PW'(NREQ - 1))
             ? '0 : win_idx + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb against a transaction-level model.
// Honours ADD_SHARE_SAT_EN for expected saturated sums.
module tb_add_share_arb;
  import add_share_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int VW   = 2*NREQ + W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      sum;
  logic              carry;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  // model: an op occupies the two cycles after its grant edge
  int         m_left;
  int         m_ptr;
  int         m_win;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_sum;
  logic         m_carry;

  always #5 clk = ~clk;

  add_share_arb #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .req   (req),
    .op_a  (op_a),
    .op_b  (op_b),
    .ack   (ack),
    .gnt   (gnt),
    .sum   (sum),
    .carry (carry),
    .busy  (busy)
  );

  task automatic model_reset();
    m_left  = 0;
    m_ptr   = 0;
    m_win   = 0;
    m_a     = '0;
    m_b     = '0;
    m_sum   = '0;
    m_carry = 1'b0;
  endtask

  task automatic model_edge();
    int tot;
    bit found;
    if (m_left == 2) begin
      tot     = int'(m_a) + int'(m_b);
      m_carry = (tot >= (1 << W));
      m_sum   = W'(tot);
`ifdef ADD_SHARE_SAT_EN
      if (m_carry) m_sum = '1;
`endif
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
      m_ptr  = (m_win + 1) % NREQ;
    end else if (ena && req != '0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (!found && req[j]) begin
          found = 1;
          m_win = j;
        end
      end
      m_a    = op_a[m_win*W +: W];
      m_b    = op_b[m_win*W +: W];
      m_left = 2;
    end
  endtask

  function automatic logic [VW-1:0] exp_all();
    logic [NREQ-1:0] g;
    g = (m_left > 0) ? NREQ'(1 << m_win) : '0;
    return {(m_left == 1) ? g : NREQ'(0), g,
            m_left > 0, m_carry, m_sum};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bit seen;
    apply_reset();
    vectors++;
    if ({ack, gnt, busy, carry, sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=0",
               {ack, gnt, busy, carry, sum});
    end
    req[0] = 1'b1;
    op_a[0 +: W] = 8'h21;
    op_b[0 +: W] = 8'h13;
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step();
      vectors++;
      if ({ack, gnt, busy, carry, sum} !== exp_all()) begin
        miscompares++;
        $display("FAIL reset_pre c%0d got=%h exp=%h", c,
                 {ack, gnt, busy, carry, sum}, exp_all());
      end
      if (ack[0]) begin
        seen = 1;
        req[0] = 1'b0;
      end
    end
    step();
    req[1] = 1'b1;
    op_a[W +: W] = 8'h40;
    op_b[W +: W] = 8'h02;
    step();
    vectors++;
    if (gnt !== 2'b10 || sum !== 8'h34) begin
      miscompares++;
      $display("FAIL reset_exec gnt=%b sum=%h exp gnt=10 sum=34",
               gnt, sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack, gnt, busy, carry, sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=0",
               {ack, gnt, busy, carry, sum});
    end
    req = '0;
    model_reset();
    step();
    vectors++;
    if ({ack, gnt, busy, carry, sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=0",
               {ack, gnt, busy, carry, sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit seen;
    int lat;
    logic [W-1:0] s;
    logic cy;
    seen = 0;
    lat = -1;
    s = '0;
    cy = 1'b0;
    op_a[0 +: W] = 8'h12;
    op_b[0 +: W] = 8'h34;
    req[0] = 1'b1;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      vectors++;
      if ({ack, gnt, busy, carry, sum} !== exp_all()) begin
        miscompares++;
        $display("FAIL single c%0d got=%h exp=%h", c,
                 {ack, gnt, busy, carry, sum}, exp_all());
      end
      if (ack[0]) begin
        seen = 1;
        lat = c;
        s = sum;
        cy = carry;
        req[0] = 1'b0;
      end
    end
    vectors++;
    if (!seen || lat != 1 || s !== 8'h46 || cy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_res seen=%0d lat=%0d sum=%h c=%b exp 1 1 46 0",
               seen, lat, s, cy);
    end
    step();
  endtask

  task automatic test_overflow();
    bit seen;
    logic [W-1:0] s;
    logic [W-1:0] want;
    logic cy;
`ifdef ADD_SHARE_SAT_EN
    want = 8'hFF;
`else
    want = 8'h10;
`endif
    seen = 0;
    s = '0;
    cy = 1'b0;
    op_a[W +: W] = 8'hF0;
    op_b[W +: W] = 8'h20;
    req[1] = 1'b1;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      vectors++;
      if ({ack, gnt, busy, carry, sum} !== exp_all()) begin
        miscompares++;
        $display("FAIL overflow c%0d got=%h exp=%h", c,
                 {ack, gnt, busy, carry, sum}, exp_all());
      end
      if (ack[1]) begin
        seen = 1;
        s = sum;
        cy = carry;
        req[1] = 1'b0;
      end
    end
    vectors++;
    if (!seen || s !== want || cy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_res seen=%0d sum=%h c=%b exp sum=%h c=1",
               seen, s, cy, want);
    end
    step();
  endtask

  task automatic test_contention();
    int order[$];
    int n0;
    int n1;
    rst_n = 1'b0;
    ena = 1'b1;
    req = 2'b11;
    op_a = {8'h07, 8'h03};
    op_b = {8'h09, 8'h05};
    model_reset();
    n0 = 0;
    n1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      vectors++;
      if ({ack, gnt, busy, carry, sum} !== exp_all()) begin
        miscompares++;
        $display("FAIL contend c%0d got=%h exp=%h", c,
                 {ack, gnt, busy, carry, sum}, exp_all());
      end
      if (ack[0]) begin
        order.push_back(0);
        n0++;
      end
      if (ack[1]) begin
        order.push_back(1);
        n1++;
      end
    end
    vectors++;
    if (order.size() != 4 || n0 != 2 || n1 != 2 ||
        order[0] != 0 || order[1] != 1 ||
        order[2] != 0 || order[3] != 1) begin
      miscompares++;
      $display("FAIL contend_order acks=%0d n0=%0d n1=%0d exp 4 0101",
               order.size(), n0, n1);
    end
    req = '0;
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_ena();
    bit bad;
    bad = 0;
    apply_reset();
    ena = 1'b0;
    op_a[W +: W] = 8'h11;
    op_b[W +: W] = 8'h22;
    req = 2'b10;
    for (int c = 0; c < 10; c++) begin
      step();
      if (gnt !== 2'b00 || busy !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL ena_block gnt=%b busy=%b exp 00 0", gnt, busy);
    end
    ena = 1'b1;
    step();
    vectors++;
    if (gnt !== 2'b10) begin
      miscompares++;
      $display("FAIL ena_grant gnt=%b exp=10", gnt);
    end
    ena = 1'b0;
    step();
    vectors++;
    if ({ack, gnt, busy, carry, sum} !== exp_all() || ack !== 2'b10) begin
      miscompares++;
      $display("FAIL ena_complete got=%h exp=%h",
               {ack, gnt, busy, carry, sum}, exp_all());
    end
    req = '0;
    ena = 1'b1;
    step();
  endtask

  task automatic test_operand_change();
    req = '0;
    op_a[0 +: W] = 8'h55;
    op_b[0 +: W] = 8'h11;
    req[0] = 1'b1;
    step();
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL opchg_grant gnt=%b exp=01", gnt);
    end
    op_a[0 +: W] = 8'hAA;
    op_b[0 +: W] = 8'hCC;
    step();
    vectors++;
    if (ack !== 2'b01 || sum !== 8'h66 || carry !== 1'b0) begin
      miscompares++;
      $display("FAIL opchg_sum ack=%b sum=%h c=%b exp 01 66 0",
               ack, sum, carry);
    end
    req[0] = 1'b0;
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          op_a[i*W +: W] = W'($urandom);
          op_b[i*W +: W] = W'($urandom);
        end else if (req[i] && $urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end else if (req[i] && $urandom_range(7) == 0) begin
          op_a[i*W +: W] = W'($urandom);
        end
      end
      ena = ($urandom_range(5) != 0);
      step();
      vectors++;
      if ({ack, gnt, busy, carry, sum} !== exp_all()) begin
        miscompares++;
        $display("FAIL random c%0d got=%h exp=%h", c,
                 {ack, gnt, busy, carry, sum}, exp_all());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b0;
    req = '0;
    op_a = '0;
    op_b = '0;
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_ena();
    test_operand_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

endmodule
